// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl
//   Generates the board CPU clock from the free-running clkdiv counter.
//   Run mode: Clk_CPU follows a switch-selected clkdiv bit, one clk late.
//   Step mode: each debounced button press yields exactly one CPU clock
//   period (STEP_W clk high, at least STEP_W clk low).
//
// Ports
//   clk       board clock, sole clock domain (rising edge)
//   rst       asynchronous, active-high reset
//   clkdiv    free-running divider count, synchronous to clk
//   SW2       run-mode speed select (1 = slow bit)
//   SW_run    1 = free-run, 0 = single-step
//   BTN_step  raw, bouncy step button
//   Clk_CPU   registered CPU clock
//   cpu_tick  one-clk pulse in the first cycle Clk_CPU is high
//   step_cnt  count of Clk_CPU rising edges, wraps at 16 bits
module cpu_clk_ctrl #(
  parameter int unsigned FAST_BIT = 1,
  parameter int unsigned SLOW_BIT = 24,
  parameter int unsigned DB_BIT   = 16,
  parameter int unsigned DB_CNT   = 4,
  parameter int unsigned STEP_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] clkdiv,
  input  logic        SW2,
  input  logic        SW_run,
  input  logic        BTN_step,
  output logic        Clk_CPU,
  output logic        cpu_tick,
  output logic [15:0] step_cnt
);

  localparam int unsigned CW = $clog2(DB_CNT + 1);
  localparam int unsigned WW = (STEP_W > 1) ? $clog2(STEP_W) : 1;
  localparam logic [WW-1:0] W_LOAD = WW'(STEP_W - 1);
  localparam logic [CW-1:0] DB_LIMIT = CW'(DB_CNT);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    S_IDLE = 2'd1,
    S_HI   = 2'd2,
    S_LO   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [WW-1:0]   wcnt;
  logic [WW-1:0]   wcnt_n;
  logic            clk_n;
  logic            rise_n;

  logic [1:0]      sw2_sync;
  logic [1:0]      run_sync;
  logic [1:0]      btn_sync;
  logic            sw2_s;
  logic            run_s;
  logic            btn_s;

  logic            sel_q;
  logic            selbit;

  logic            db_q;
  logic            db_tick;
  logic [CW-1:0]   db_cnt;
  logic [CW-1:0]   db_inc;
  logic            btn_db;
  logic            btn_db_q;
  logic            step_req;

  // Only a few clkdiv bits are used; fold the rest into a sink.
  logic            clkdiv_unused;
  assign clkdiv_unused = ^clkdiv;

  // Two-flop synchronizers for the asynchronous board inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw2_sync <= '0;
      run_sync <= '0;
      btn_sync <= '0;
    end else begin
      sw2_sync <= {sw2_sync[0], SW2};
      run_sync <= {run_sync[0], SW_run};
      btn_sync <= {btn_sync[0], BTN_step};
    end
  end

  assign sw2_s = sw2_sync[1];
  assign run_s = run_sync[1];
  assign btn_s = btn_sync[1];

  // Speed select is only allowed to change when the CPU clock and both
  // candidate bits are low, so the mux output cannot glitch high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= 1'b0;
    end else if (!Clk_CPU && !clkdiv[FAST_BIT] && !clkdiv[SLOW_BIT]) begin
      sel_q <= sw2_s;
    end
  end

  assign selbit = sel_q ? clkdiv[SLOW_BIT] : clkdiv[FAST_BIT];

  // Debouncer: sample on each rising edge of clkdiv[DB_BIT]; the level
  // flips after DB_CNT consecutive samples disagreeing with it.
  assign db_tick = clkdiv[DB_BIT] & ~db_q;
  assign db_inc  = db_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q     <= 1'b0;
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      db_q     <= clkdiv[DB_BIT];
      btn_db_q <= btn_db;
      if (db_tick) begin
        if (btn_s != btn_db) begin
          if (db_inc == DB_LIMIT) begin
            btn_db <= ~btn_db;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_inc;
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end
  end

  assign step_req = btn_db & ~btn_db_q;

  // FSM state register plus the registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      Clk_CPU  <= 1'b0;
      cpu_tick <= 1'b0;
      step_cnt <= '0;
    end else begin
      state    <= state_n;
      wcnt     <= wcnt_n;
      Clk_CPU  <= clk_n;
      cpu_tick <= rise_n;
      step_cnt <= step_cnt + 16'(rise_n);
    end
  end

  // Next-state logic; step requests outside S_IDLE are simply ignored
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    unique case (state)
      RUN: begin
        if (!run_s && !selbit) state_n = S_IDLE;
      end
      S_IDLE: begin
        if (run_s && !selbit) begin
          state_n = RUN;
        end else if (step_req) begin
          state_n = S_HI;
          wcnt_n  = W_LOAD;
        end
      end
      S_HI: begin
        if (wcnt == '0) begin
          state_n = S_LO;
          wcnt_n  = W_LOAD;
        end else begin
          wcnt_n = wcnt - 1'b1;
        end
      end
      S_LO: begin
        if (wcnt == '0) state_n = S_IDLE;
        else            wcnt_n  = wcnt - 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output logic is driven from the next state so that a step request
  // raises Clk_CPU on the very next edge rather than one cycle later.
  always_comb begin
    clk_n = 1'b0;
    unique case (state_n)
      RUN:     clk_n = selbit;
      S_HI:    clk_n = 1'b1;
      default: clk_n = 1'b0;
    endcase
    rise_n = clk_n & ~Clk_CPU;
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl. A second instance with a very fast
// debouncer produces two step requests close enough to land inside a step.
module tb_cpu_clk_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] div;
  logic        SW2 = 1'b0;
  logic        SW_run = 1'b0;
  logic        btn = 1'b0;
  logic        btn2 = 1'b0;
  logic        Clk_CPU, cpu_tick;
  logic [15:0] step_cnt;
  logic        clk2, tick2;
  logic [15:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) div <= '0;
    else     div <= div + 1;
  end

  cpu_clk_ctrl #(
    .FAST_BIT(1), .SLOW_BIT(3), .DB_BIT(2), .DB_CNT(3), .STEP_W(2)
  ) dut (
    .clk(clk), .rst(rst), .clkdiv(div), .SW2(SW2), .SW_run(SW_run),
    .BTN_step(btn), .Clk_CPU(Clk_CPU), .cpu_tick(cpu_tick), .step_cnt(step_cnt)
  );

  cpu_clk_ctrl #(
    .FAST_BIT(1), .SLOW_BIT(3), .DB_BIT(0), .DB_CNT(1), .STEP_W(2)
  ) dut2 (
    .clk(clk), .rst(rst), .clkdiv(div), .SW2(SW2), .SW_run(SW_run),
    .BTN_step(btn2), .Clk_CPU(clk2), .cpu_tick(tick2), .step_cnt(cnt2)
  );

  typedef struct {
    logic        run;
    logic        sw2;
    int unsigned mode;      // 0 btn low, 1 btn high, 2 bounce then high
    int unsigned cycles;
    int unsigned exp_rises;
    int unsigned exp_hi;
  } vec_t;

  vec_t vecs[5];

  // observation state for the main instance
  logic        prev_clk = 1'b0;
  logic [31:0] div_s = '0;
  logic [31:0] prev_div = '0;
  int          rises, tick_bad, hi_len, hi_min, hi_max;
  bit          hi_valid;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr_stats();
    rises = 0; tick_bad = 0; hi_len = 0; hi_min = 999; hi_max = 0; hi_valid = 0;
  endtask

  // advance one clk and sample on the falling edge
  task automatic step1();
    logic cur;
    @(posedge clk);
    @(negedge clk);
    cur = Clk_CPU;
    if (cpu_tick !== (cur && !prev_clk)) tick_bad++;
    if (cur && !prev_clk) begin
      rises++; hi_len = 1; hi_valid = 1;
    end else if (cur) begin
      hi_len++;
    end else if (prev_clk && hi_valid) begin
      if (hi_len < hi_min) hi_min = hi_len;
      if (hi_len > hi_max) hi_max = hi_len;
    end
    prev_clk = cur;
    prev_div = div_s;
    div_s    = div;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c0, d16, c2;
    int lag_bad, exp_idx, got_idx, r1, n, hi, reqs2, rises2;
    logic p2;
    bit found;

    vecs[0] = '{run: 1'b0, sw2: 1'b1, mode: 0, cycles: 30, exp_rises: 0, exp_hi: 0};
    vecs[1] = '{run: 1'b0, sw2: 1'b1, mode: 1, cycles: 40, exp_rises: 1, exp_hi: 2};
    vecs[2] = '{run: 1'b0, sw2: 1'b1, mode: 0, cycles: 40, exp_rises: 0, exp_hi: 0};
    vecs[3] = '{run: 1'b0, sw2: 1'b1, mode: 2, cycles: 70, exp_rises: 1, exp_hi: 2};
    vecs[4] = '{run: 1'b0, sw2: 1'b1, mode: 0, cycles: 40, exp_rises: 0, exp_hi: 0};
    clr_stats();

    // reset values
    step1();
    check("rst_clk", 32'(Clk_CPU), 0);
    check("rst_tick", 32'(cpu_tick), 0);
    check("rst_cnt", 32'(step_cnt), 0);
    check("rst_cnt2", 32'(cnt2), 0);
    rst = 1'b0;

    // free-run, fast bit
    SW_run = 1'b1; SW2 = 1'b0;
    repeat (8) step1();
    clr_stats(); c0 = step_cnt; lag_bad = 0;
    for (int i = 0; i < 64; i++) begin
      step1();
      if (Clk_CPU !== prev_div[1]) lag_bad++;
    end
    d16 = step_cnt - c0;
    check("run_lag", 32'(lag_bad), 0);
    check("run_rises", 32'(rises), 16);
    check("run_cnt", 32'(d16), 16);
    check("run_tick", 32'(tick_bad), 0);

    // speed switch while clkdiv[1] is high
    for (int i = 0; i < 8 && !div_s[1]; i++) step1();
    SW2 = 1'b1; clr_stats(); exp_idx = -1; got_idx = -1;
    for (int i = 1; i <= 60; i++) begin
      step1();
      if (i >= 2 && exp_idx < 0 && !Clk_CPU && !div_s[1] && !div_s[3]) exp_idx = i + 1;
      if (got_idx < 0 && dut.sel_q) got_idx = i;
    end
    check("sel_latch", 32'(got_idx), 32'(exp_idx));
    r1 = rises;
    for (int i = 0; i < 40 && rises == r1; i++) step1();
    r1 = rises; n = 0; hi = 1; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step1(); n++;
      if (rises != r1) found = 1;
      else if (Clk_CPU) hi++;
    end
    check("slow_period", 32'(n), 16);
    check("slow_high", 32'(hi), 8);
    check("switch_min_hi", 32'(hi_min >= 2), 1);
    check("switch_tick", 32'(tick_bad), 0);

    // leave run mode
    SW_run = 1'b0;
    repeat (40) step1();

    // step-mode vector table
    for (int v = 0; v < 5; v++) begin
      SW_run = vecs[v].run; SW2 = vecs[v].sw2;
      clr_stats(); c0 = step_cnt;
      for (int c = 0; c < int'(vecs[v].cycles); c++) begin
        case (vecs[v].mode)
          0:       btn = 1'b0;
          1:       btn = 1'b1;
          default: btn = (c >= 30) ? 1'b1 : (((c / 3) % 2) == 0);
        endcase
        step1();
      end
      d16 = step_cnt - c0;
      check($sformatf("vec%0d_rises", v), 32'(rises), vecs[v].exp_rises);
      check($sformatf("vec%0d_cnt", v), 32'(d16), vecs[v].exp_rises);
      check($sformatf("vec%0d_tick", v), 32'(tick_bad), 0);
      if (vecs[v].exp_rises > 0) begin
        check($sformatf("vec%0d_hi_min", v), 32'(hi_min), vecs[v].exp_hi);
        check($sformatf("vec%0d_hi_max", v), 32'(hi_max), vecs[v].exp_hi);
      end
    end

    // second request lands in S_LO of the fast-debounce instance
    c2 = cnt2; reqs2 = 0; rises2 = 0; p2 = clk2;
    for (int c = 0; c < 56; c++) begin
      if (c < 6)       btn2 = (c == 2 || c == 3) ? 1'b0 : 1'b1;
      else if (c < 26) btn2 = 1'b1;
      else             btn2 = 1'b0;
      step1();
      if (dut2.step_req) reqs2++;
      if (clk2 && !p2) rises2++;
      p2 = clk2;
    end
    d16 = cnt2 - c2;
    check("drop_reqs", 32'(reqs2), 2);
    check("drop_rises", 32'(rises2), 1);
    check("drop_cnt", 32'(d16), 1);

    // wrap of step_cnt, and request-to-clock latency
    force dut.step_cnt = 16'hFFFF;
    step1();
    release dut.step_cnt;
    btn = 1'b1; found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step1();
      if (dut.step_req) found = 1;
    end
    check("wrap_req_seen", 32'(found), 1);
    step1();
    check("wrap_clk", 32'(Clk_CPU), 1);
    check("wrap_tick", 32'(cpu_tick), 1);
    check("wrap_cnt", 32'(step_cnt), 0);

    // reset during S_HI
    rst = 1'b1; btn = 1'b0;
    #1;
    check("rst_hi_clk", 32'(Clk_CPU), 0);
    check("rst_hi_cnt", 32'(step_cnt), 0);
    check("rst_hi_tick", 32'(cpu_tick), 0);
    step1(); step1();
    rst = 1'b0;
    clr_stats();
    repeat (30) step1();
    check("post_rst_rises", 32'(rises), 0);
    check("post_rst_cnt", 32'(step_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
